// File: rtl/gate_pkg.sv
// gate_pkg
// Shared definitions for the gate input debouncer.
//   deb_state_t            : per-channel debounce FSM state
//   DEFAULT_STABLE_CYCLES  : default number of consecutive disagreeing cycles
//                            needed before a debounced output follows its input
package gate_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch
// One debounce channel: a 2-flop synchronizer followed by a 2-state
// debounce FSM. The output follows the synchronized input only after it has
// disagreed with the output for STABLE_CYCLES consecutive cycles.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous, active-high reset
//   raw  in   asynchronous switch/button level
//   out  out  debounced level (registered)
//   chg  out  one-cycle pulse in the cycle following an update of out
// Parameters:
//   STABLE_CYCLES  2..65535
//   CNT_W          counter width, 2**CNT_W must exceed STABLE_CYCLES
module debounce_ch
    import gate_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out,
    output logic chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_nxt;
    logic             chg_nxt;

    // Synchronizer plus FSM registers; reset wins over any pending update,
    // including one that would complete on this very edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            out   <= 1'b0;
            chg   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
            chg   <= chg_nxt;
        end
    end

    // Next-state logic. Entering PENDING already counts the first
    // disagreeing cycle, so the update lands when cnt reaches
    // STABLE_CYCLES-1 and the counter can never exceed that value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        chg_nxt   = 1'b0;
        case (state)
            STABLE: begin
                if (s2 != out) begin
                    state_nxt = PENDING;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PENDING: begin
                if (s2 == out) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                    out_nxt   = s2;
                    chg_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/gate_input_debounce.sv
// gate_input_debounce
// Debounces the two raw switch inputs that feed the downstream nor_gate.
// Each channel is an independent debounce_ch instance with no shared state.
// Ports:
//   clk    in   rising-edge system clock
//   rst    in   synchronous, active-high reset
//   a_raw  in   asynchronous input, channel A
//   b_raw  in   asynchronous input, channel B
//   a      out  debounced level A (flop-driven)
//   b      out  debounced level B (flop-driven)
//   a_chg  out  one-cycle pulse after a changes
//   b_chg  out  one-cycle pulse after b changes
module gate_input_debounce
    import gate_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_chg,
    output logic b_chg
);

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_a (
        .clk (clk),
        .rst (rst),
        .raw (a_raw),
        .out (a),
        .chg (a_chg)
    );

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_b (
        .clk (clk),
        .rst (rst),
        .raw (b_raw),
        .out (b),
        .chg (b_chg)
    );

endmodule
